prga_fifo_upsizer: RTL
======================

# prga_fifo_upsizer

Width-up converter that sits directly downstream of a lookahead `prga_fifo` and consumes its narrow words. It packs `MULTIPLIER` consecutive `DATA_WIDTH`-bit words into one wide word. It presents that wide word on a lookahead FIFO-style read interface to the next stage. Non-lookahead sources are first converted with `prga_fifo_lookahead_buffer`.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of one narrow input word.
- `MULTIPLIER`, 4, narrow words per wide output word; legal range 2..16.
- `MSB_FIRST`, 0, packing order:
  - 0: first-received word occupies `dout[DATA_WIDTH-1:0]`.
  - 1: first-received word occupies the top slot.

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset; one clock; reset is asynchronous and active-low. Asserted at 0.
- `empty_i`  input  1  upstream lookahead FIFO empty.
- `rd_i`  output  1  read strobe to the upstream FIFO; consumes `dout_i` this cycle.
- `dout_i`  input  `DATA_WIDTH`  upstream head word; valid whenever `empty_i`=0.
- `empty`  output  1  no complete wide word available.
- `rd`  input  1  downstream read strobe; consumes `dout` this cycle.
- `dout`  output  `DATA_WIDTH*MULTIPLIER`  packed wide word; valid whenever `empty`=0.

## Operation
State:
- Slot buffer: `MULTIPLIER` × `DATA_WIDTH` registers.
- Fill counter `cnt`: `clog2(MULTIPLIER+1)` bits, range 0..`MULTIPLIER`.

Rules:
- `empty` = (`cnt` != `MULTIPLIER`), purely from registered state.
- `dout` = concatenation of the slots in the order set by `MSB_FIRST`. It is combinational from registers, with no logic from `rd`.
- `rd_i` = `!empty_i && (cnt < MULTIPLIER || rd)`. It is combinational from `empty_i`, `cnt` and `rd`, and never asserts while `empty_i`=1.
- Effective downstream pop: `pop` = `rd && !empty`. `rd` while `empty`=1 is ignored; no state change, no error.
- Per-edge update:
  - pop=0, rd_i=1: write `dout_i` to slot `cnt`; `cnt`+=1.
  - pop=1, rd_i=0: `cnt`←0.
  - pop=1, rd_i=1: write `dout_i` to slot 0; `cnt`←1. This is the simultaneous drain-and-fill case, so there is no bubble.
  - pop=0, rd_i=0: hold.
- Slot contents beyond `cnt` are don't-care. They are not cleared on pop, and are not observable because `empty`=1 until the word is full.
- The block never drops or duplicates a narrow word. Output order equals input order.
- No partial-word flush: a trailing group of fewer than `MULTIPLIER` words stays buffered indefinitely.

## Timing
- Reset (`rst`=0, asynchronous):
  - `cnt`←0, so `empty`=1.
  - `dout`=0: slots are reset to 0.
  - `rd_i` follows its equation, i.e. 1 if `empty_i`=0.
- Release is synchronous to the design's reset synchronizer. The first capture happens at the first rising edge with `rst`=1.
- Latency: `empty` falls immediately after the edge that captures the `MULTIPLIER`-th word of a group. With a continuously non-empty source, that is `MULTIPLIER` cycles after the first `rd_i`.
- Throughput: with the source never empty and `rd` held high, one wide word per `MULTIPLIER` cycles. `rd_i` stays 1 every cycle.
- Backpressure:
  - When `cnt`=`MULTIPLIER` and `rd`=0, `rd_i`=0 and the upstream FIFO holds.
  - `dout` is stable until popped.
- Reset mid-group: partially collected words are discarded. Upstream words already consumed are lost, which is acceptable.

## Test plan
- **Reset:** drive `rst`=0 asynchronously mid-cycle with `cnt`=2 → `empty`=1 and `dout`=0 without waiting for a clock edge. After release, `cnt` restarts at 0.
- **Basic pack** (`MULTIPLIER`=4, `MSB_FIRST`=0): source 0x11,0x22,0x33,0x44 back-to-back, `rd`=0 → `empty` falls after the 4th capture, `dout`=0x44332211. `rd_i`=0 from then on while `rd`=0.
- **Ordering** (`MSB_FIRST`=1): same stimulus → `dout`=0x11223344.
- **Streaming:** 16 words 0x00..0x0F with `rd` tied high → 4 wide words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C. `rd_i` is high on all 16 cycles, with no bubbles.
- **Source gaps:** `empty_i` toggles 1/0 every cycle → no capture while `empty_i`=1. The wide word still completes correctly after 4 valid words.
- **Spurious read and stall:**
  - `rd`=1 while `empty`=1 → no state change.
  - Full word held 10 cycles with `rd`=0 → `dout` stable and `rd_i`=0 throughout. The following pop with the source non-empty yields `cnt`=1 on the same edge.

Source files
------------

// File: rtl/prga_fifo_upsizer.sv
// ---------------------------------------------------------------------------
// prga_fifo_upsizer
//
// Width-up converter placed directly behind a lookahead prga_fifo. Collects
// MULTIPLIER consecutive DATA_WIDTH-bit words from the upstream FIFO and
// presents them as one wide word on a lookahead FIFO-style read interface.
//
// Parameters
//   DATA_WIDTH  width of one narrow input word
//   MULTIPLIER  narrow words per wide word (2..16)
//   MSB_FIRST   0: first-received word in dout[DATA_WIDTH-1:0]
//               1: first-received word in the top slot of dout
//
// Ports
//   clk      in   clock, all state changes on the rising edge
//   rst      in   asynchronous reset, active low
//   empty_i  in   upstream lookahead FIFO is empty
//   rd_i     out  read strobe to upstream; consumes dout_i this cycle
//   dout_i   in   upstream head word, valid while empty_i = 0
//   empty    out  no complete wide word available
//   rd       in   downstream read strobe; consumes dout this cycle
//   dout     out  packed wide word, valid while empty = 0
//
// The wide word is handed over in the same cycle that the first word of the
// next group is captured (pop and fill together), so a continuously fed
// source streams one wide word every MULTIPLIER cycles with rd_i always high.
// A trailing partial group is never flushed; it waits for more input.
// ---------------------------------------------------------------------------
module prga_fifo_upsizer #(
  parameter int DATA_WIDTH = 8,
  parameter int MULTIPLIER = 4,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             empty_i,
  output logic                             rd_i,
  input  logic [DATA_WIDTH-1:0]            dout_i,
  output logic                             empty,
  input  logic                             rd,
  output logic [DATA_WIDTH*MULTIPLIER-1:0] dout
);

  // Counter must represent 0..MULTIPLIER inclusive.
  localparam int              CNT_W = $clog2(MULTIPLIER + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MULTIPLIER);

  logic [DATA_WIDTH-1:0] slots [MULTIPLIER];
  logic [CNT_W-1:0]      cnt;

  logic                  pop;
  logic [CNT_W-1:0]      wr_idx;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  // empty depends only on the fill counter, so downstream sees a registered
  // status with no combinational path from rd.
  assign empty = (cnt != FULL);

  // A read while empty is simply ignored.
  assign pop = rd && !empty;

  // Accept upstream data whenever there is room, or when the full word is
  // leaving this cycle and slot 0 frees up. When full, rd implies pop.
  assign rd_i = !empty_i && ((cnt < FULL) || rd);

  // A pop restarts the group, so the incoming word lands in slot 0.
  assign wr_idx = pop ? '0 : cnt;

  // -------------------------------------------------------------------------
  // Fill counter
  // -------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      unique case ({pop, rd_i})
        2'b01:   cnt <= cnt + CNT_W'(1);
        2'b10:   cnt <= '0;
        2'b11:   cnt <= CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Slot buffer
  // -------------------------------------------------------------------------
  // NOTE: the slots are reset even though they are storage, because dout must
  // read as zero during reset. Slots above cnt are left stale after a pop;
  // they are never visible while empty is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MULTIPLIER; i++) begin
        slots[i] <= '0;
      end
    end else if (rd_i) begin
      for (int i = 0; i < MULTIPLIER; i++) begin
        if (wr_idx == CNT_W'(i)) begin
          slots[i] <= dout_i;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output packing
  // -------------------------------------------------------------------------
  // NOTE: dout gets a full default before the loop so no bit can hold its old
  // value through the combinational block and infer a latch.
  always_comb begin
    dout = '0;
    for (int i = 0; i < MULTIPLIER; i++) begin
      if (MSB_FIRST) begin
        dout[(MULTIPLIER-1-i)*DATA_WIDTH +: DATA_WIDTH] = slots[i];
      end else begin
        dout[i*DATA_WIDTH +: DATA_WIDTH] = slots[i];
      end
    end
  end

endmodule
